pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and fetch sequencer for the 8-bit single-stage core. Fetches the
//  instruction at pc over a req/ack handshake and presents it to the decoder for
//  exactly one cycle. Takes PCbranch/PCincr/branchEn back from the decoder, computes
//  the next pc, and detects halt (jump-to-self) and fetch timeouts.
// PARAMETERS
//  PC_W           8    program counter / instruction address width, >= 5
//  FETCH_TIMEOUT  15   max cycles from imem_req to imem_ack before fault; >= 1
// PORTS
//  clk          in   1     single clock; all state on rising edge
//  nReset       in   1     asynchronous, active-low reset
//  run          in   1     level; start/continue execution
//  imem_req     out  1     fetch request to instruction memory
//  imem_addr    out  PC_W  fetch address (= pc while imem_req=1)
//  imem_ack     in   1     memory has imem_rdata valid this cycle
//  imem_rdata   in   8     instruction word
//  instr        out  8     latched instruction to decoder ([7:5] opcode, [4:0] imm)
//  instr_valid  out  1     decoder outputs are used this cycle (EXEC)
//  PCbranch     in   1     from decoder: take branch/jump
//  PCincr       in   1     from decoder: advance pc by 1
//  branchEn     in   1     from decoder: conditional branch instruction
//  pc           out  PC_W  current program counter
//  halted       out  1     sequencer in HALT
//  fault        out  1     HALT was entered by fetch timeout
// BEHAVIOUR
//  Reset (async, nReset=0): state=IDLE, pc=0, instr=8'h00, imem_req=0, imem_addr=0,
//   instr_valid=0, halted=0, fault=0, timeout counter=0. Outputs clear immediately,
//   including mid-fetch (imem_req drops in the same cycle nReset falls).
//  States:
//   IDLE : all strobes 0. run=1 -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> instr<=imem_rdata, goto EXEC.
//          Count cycles with no ack; on the cycle the count reaches FETCH_TIMEOUT with
//          still no ack -> HALT, fault<=1. An ack in that same cycle wins (no fault).
//   EXEC : instr_valid=1 for exactly one cycle; PCbranch/PCincr are sampled now.
//          pc<=next_pc. If PCbranch=1 and instr[4:0]=0 -> HALT, fault stays 0.
//          Else if run=0 -> IDLE. Else -> FETCH.
//   HALT : halted=1, pc frozen. Exit only when run=0 -> IDLE (fault cleared on exit).
//  next_pc (EXEC only): PCbranch=1 -> pc + sext(instr[4:0]) (range -16..+15);
//   else if PCincr=1 -> pc + 1; else pc unchanged. PCbranch has priority.
//   All arithmetic modulo 2^PC_W (pc=max + 1 -> 0; pc=2 + (-16) wraps).
//  Throughput: 1 instruction per (ack latency + 2) cycles. With ack in the first
//   FETCH cycle, instr_valid pulses every 2nd cycle.
//  imem_ack outside FETCH is ignored. Inputs from the decoder are ignored outside EXEC.
//  run falling during FETCH: the fetch completes and EXEC runs; IDLE follows EXEC.
// CONFIGURATION
//  PERF_CNT_EN defined: adds outputs instr_cnt[15:0] (+1 per EXEC cycle) and
//   br_taken_cnt[15:0] (+1 per EXEC with branchEn=1 and PCbranch=1). Both saturate
//   at 16'hFFFF, reset to 0 on nReset, hold while IDLE/HALT.
//  Not defined: these ports and their counters do not exist; all other
//   behaviour is identical.
// TESTING
//  1 reset, run=1, ack in first FETCH cycle, PCincr=1 every EXEC -> imem_addr 0,1,2,3;
//    instr_valid every 2nd cycle; pc=4 after 4 EXECs.
//  2 pc=8'h05, instr=8'b101_11101 (imm -3), PCbranch=1 -> pc=8'h02; imm +15 at
//    pc=8'hF5 -> pc=8'h04 (wrap).
//  3 instr imm=0 with PCbranch=1 at pc=7 -> halted=1, fault=0, pc stays 7; run=0 ->
//    IDLE, halted=0.
//  4 ack withheld 15 cycles -> HALT, fault=1, imem_req=0; ack on the 15th cycle ->
//    EXEC, no fault.
//  5 nReset pulsed low mid-FETCH with imem_req=1 -> imem_req=0, pc=0, state IDLE at once.
//  6 PERF_CNT_EN: 3 EXECs of which 1 taken branch -> instr_cnt=3, br_taken_cnt=1;
//    preload near 16'hFFFF -> saturates.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and fetch sequencer for the 8-bit single-stage core.
// Latency: one instruction per (ack latency + 2) cycles; instr_valid pulses for one EXEC cycle.
// Backpressure: FETCH holds imem_req until imem_ack; a missing ack for FETCH_TIMEOUT cycles halts with fault.
//
// Ports:
//   clk, nReset                 clock, asynchronous active-low reset
//   run                         level start/continue request
//   imem_req/addr/ack/rdata     instruction fetch handshake
//   instr, instr_valid          latched instruction and its one-cycle EXEC strobe
//   PCbranch, PCincr, branchEn  decoder feedback, sampled only in EXEC
//   pc, halted, fault           program counter and halt status
// Optional build macro PERF_CNT_EN adds saturating instr_cnt / br_taken_cnt outputs.
module pc_sequencer #(
  parameter int PC_W          = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr,
  output logic            instr_valid,
  input  logic            PCbranch,
  input  logic            PCincr,
  input  logic            branchEn,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]     instr_cnt,
  output logic [15:0]     br_taken_cnt
`endif
);

  localparam int CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  // Value of the no-ack counter during the last allowed FETCH cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       instr_q, instr_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  imm_sext;

  // Branch offset is the 5-bit signed immediate, widened to pc width.
  assign imm_sext = {{(PC_W-5){instr_q[4]}}, instr_q[4:0]};

  always_comb begin
    next_pc = pc_q;
    if (PCbranch) begin
      next_pc = pc_q + imm_sext;
    end else if (PCincr) begin
      next_pc = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= 8'h00;
      fault_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    tmo_d       = tmo_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        // An ack in the final allowed cycle takes priority over the timeout.
        if (imem_ack) begin
          instr_d = imem_rdata;
          tmo_d   = '0;
          state_d = S_EXEC;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      S_EXEC: begin
        instr_valid = 1'b1;
        pc_d        = next_pc;
        // A taken jump with zero offset is a jump-to-self: the program is done.
        if (PCbranch && (instr_q[4:0] == 5'd0)) begin
          state_d = S_HALT;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        if (!run) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = imem_req ? pc_q : '0;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;

`ifdef PERF_CNT_EN
  logic [15:0] instr_cnt_q;
  logic [15:0] br_taken_cnt_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      instr_cnt_q    <= 16'h0000;
      br_taken_cnt_q <= 16'h0000;
    end else if (state_q == S_EXEC) begin
      if (instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
      if (branchEn && PCbranch && (br_taken_cnt_q != 16'hFFFF)) begin
        br_taken_cnt_q <= br_taken_cnt_q + 16'd1;
      end
    end
  end

  assign instr_cnt    = instr_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`else
  // branchEn only feeds the performance counters.
  logic unused_branch_en;
  assign unused_branch_en = branchEn;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for the fetch/pc sequencer.
// Latency: checks sampled on falling edges, one EXEC per fetch_exec call.
// Backpressure: ack withheld to exercise timeout; ack in last cycle must win.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       nReset;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       PCbranch;
    logic       PCincr;
    logic       branchEn;
    logic [7:0] pc;
    logic       halted;
    logic       fault;
`ifdef PERF_CNT_EN
    logic [15:0] instr_cnt;
    logic [15:0] br_taken_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(8), .FETCH_TIMEOUT(15)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .PCbranch    (PCbranch),
        .PCincr      (PCincr),
        .branchEn    (branchEn),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
`ifdef PERF_CNT_EN
        ,
        .instr_cnt   (instr_cnt),
        .br_taken_cnt(br_taken_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_exec(input logic [7:0] rd, input logic br, input logic inc,
                              input logic be, input logic [7:0] exp_addr);
        chk("fetch_req", 16'(imem_req), 16'(1'b1));
        chk("fetch_addr", 16'(imem_addr), 16'(exp_addr));
        chk("fetch_no_valid", 16'(instr_valid), 16'(1'b0));
        imem_ack   = 1'b1;
        imem_rdata = rd;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("exec_valid", 16'(instr_valid), 16'(1'b1));
        chk("exec_instr", 16'(instr), 16'(rd));
        chk("exec_no_req", 16'(imem_req), 16'(1'b0));
        PCbranch = br;
        PCincr   = inc;
        branchEn = be;
        @(negedge clk);
        PCbranch = 1'b0;
        PCincr   = 1'b0;
        branchEn = 1'b0;
    endtask

    initial begin
        nReset     = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        PCbranch   = 1'b0;
        PCincr     = 1'b0;
        branchEn   = 1'b0;

        @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'(1'b0));
        chk("rst_addr", 16'(imem_addr), 16'h00);
        chk("rst_pc", 16'(pc), 16'h00);
        chk("rst_instr", 16'(instr), 16'h00);
        chk("rst_valid", 16'(instr_valid), 16'(1'b0));
        chk("rst_halted", 16'(halted), 16'(1'b0));
        chk("rst_fault", 16'(fault), 16'(1'b0));

        nReset = 1'b1;
        run    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'(i));
            chk("seq_pc", 16'(pc), 16'(i + 1));
        end

        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'h04);
        chk("pc_5", 16'(pc), 16'h05);
        fetch_exec(8'b101_11101, 1'b1, 1'b0, 1'b1, 8'h05);
        chk("br_minus3", 16'(pc), 16'h02);
        fetch_exec(8'b000_10011, 1'b1, 1'b0, 1'b1, 8'h02);
        chk("br_minus13_wrap", 16'(pc), 16'hF5);
        fetch_exec(8'b000_01111, 1'b1, 1'b0, 1'b1, 8'hF5);
        chk("br_plus15_wrap", 16'(pc), 16'h04);
        fetch_exec(8'h00, 1'b0, 1'b0, 1'b0, 8'h04);
        chk("no_advance", 16'(pc), 16'h04);
        fetch_exec(8'b000_00011, 1'b1, 1'b1, 1'b1, 8'h04);
        chk("br_priority", 16'(pc), 16'h07);
        fetch_exec(8'b000_11000, 1'b1, 1'b0, 1'b1, 8'h07);
        chk("br_minus8", 16'(pc), 16'hFF);
        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'hFF);
        chk("incr_wrap", 16'(pc), 16'h00);
        fetch_exec(8'b000_00111, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("br_plus7", 16'(pc), 16'h07);

        fetch_exec(8'b111_00000, 1'b1, 1'b0, 1'b0, 8'h07);
        chk("halt_self", 16'(halted), 16'(1'b1));
        chk("halt_self_fault", 16'(fault), 16'(1'b0));
        chk("halt_self_pc", 16'(pc), 16'h07);
        chk("halt_self_req", 16'(imem_req), 16'(1'b0));
        imem_ack = 1'b1;
        PCincr   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        PCincr   = 1'b0;
        chk("halt_hold", 16'(halted), 16'(1'b1));
        chk("halt_pc_frozen", 16'(pc), 16'h07);
        run = 1'b0;
        @(negedge clk);
        chk("halt_exit", 16'(halted), 16'(1'b0));
        chk("idle_req", 16'(imem_req), 16'(1'b0));
        PCincr = 1'b1;
        @(negedge clk);
        PCincr = 1'b0;
        chk("idle_ignores_incr", 16'(pc), 16'h07);

        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("runfall_req0", 16'(imem_req), 16'(1'b1));
        @(negedge clk);
        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'h07);
        chk("runfall_idle_req", 16'(imem_req), 16'(1'b0));
        chk("runfall_pc", 16'(pc), 16'h08);
        @(negedge clk);
        chk("runfall_stay_idle", 16'(imem_req), 16'(1'b0));

        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk("tmo_req", 16'(imem_req), 16'(1'b1));
            @(negedge clk);
        end
        chk("tmo_halted", 16'(halted), 16'(1'b1));
        chk("tmo_fault", 16'(fault), 16'(1'b1));
        chk("tmo_req_drop", 16'(imem_req), 16'(1'b0));
        chk("tmo_pc", 16'(pc), 16'h08);
        run = 1'b0;
        @(negedge clk);
        chk("tmo_exit_halted", 16'(halted), 16'(1'b0));
        chk("tmo_exit_fault", 16'(fault), 16'(1'b0));

        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            chk("late_req", 16'(imem_req), 16'(1'b1));
            @(negedge clk);
        end
        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'h08);
        chk("late_fault", 16'(fault), 16'(1'b0));
        chk("late_halted", 16'(halted), 16'(1'b0));
        chk("late_pc", 16'(pc), 16'h09);

        chk("arst_pre_req", 16'(imem_req), 16'(1'b1));
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_req", 16'(imem_req), 16'(1'b0));
        chk("arst_addr", 16'(imem_addr), 16'h00);
        chk("arst_pc", 16'(pc), 16'h00);
        chk("arst_valid", 16'(instr_valid), 16'(1'b0));
        chk("arst_halted", 16'(halted), 16'(1'b0));
        @(negedge clk);
        run    = 1'b0;
        nReset = 1'b1;
        @(negedge clk);
        chk("arst_idle_req", 16'(imem_req), 16'(1'b0));
        chk("arst_idle_pc", 16'(pc), 16'h00);

`ifdef PERF_CNT_EN
        chk("perf_rst_instr", instr_cnt, 16'd0);
        chk("perf_rst_br", br_taken_cnt, 16'd0);
        run = 1'b1;
        @(negedge clk);
        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        fetch_exec(8'b000_00010, 1'b1, 1'b0, 1'b1, 8'h01);
        run = 1'b0;
        fetch_exec(8'h00, 1'b0, 1'b1, 1'b0, 8'h03);
        @(negedge clk);
        chk("perf_instr_cnt", instr_cnt, 16'd3);
        chk("perf_br_cnt", br_taken_cnt, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
